interpolator_pipe: RTL and testbench

Parametrised, fully pipelined successor to the 11-bit interpolator stage of the SPR datapath. It computes out = lobound + (upbound-lobound)*(pixel-low)/(high-low) per pixel. It clamps out-of-range pixels, guards degenerate intervals and completes the division in a bit-serial pipelined divider. One result is produced per clock, and hs/vs are carried through with matching latency.

---
 rtl/interpolator_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_interpolator_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/interpolator_pipe.sv
// interpolator_pipe: maps a pixel level from [low, high] onto [lobound, upbound].
// Out-of-range pixels are clamped. Degenerate intervals and inverted bounds are flagged.
// A restoring divider resolves one quotient bit per stage, MSB first.
// One result is produced per clock, with a fixed latency of BND_W+3 registers.
module interpolator_pipe #(
  parameter int PIX_W = 11,
  parameter int BND_W = 8,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic [PIX_W-1:0] lowLevel,
  input  logic [PIX_W-1:0] highLevel,
  input  logic [BND_W-1:0] lobound,
  input  logic [BND_W-1:0] upbound,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_valid,
  output logic [BND_W-1:0] o_delta,
  output logic [BND_W-1:0] o_value,
  output logic [1:0]       o_flag
);

  localparam int LAT = BND_W + 3;
  localparam int PW  = PIX_W + BND_W;

  logic             v_in;
  logic             flag_up;
  logic             flag_iv;
  logic [BND_W-1:0] bdiff_in;
  logic [PIX_W-1:0] intv_in;
  logic [PIX_W-1:0] alpha_in;

  logic             s1_v;
  logic [BND_W-1:0] s1_bdiff;
  logic [PIX_W-1:0] s1_intv;
  logic [PIX_W-1:0] s1_alpha;
  logic [BND_W-1:0] s1_lo;
  logic [1:0]       s1_flag;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    rnd_add;

  // Divider pipeline. Index 0 is the multiply stage; index k+1 is the output of divider stage k.
  logic             dv    [0:BND_W];
  logic [PW-1:0]    drem  [0:BND_W];
  logic [PIX_W-1:0] dintv [0:BND_W];
  logic [BND_W-1:0] dlo   [0:BND_W];
  logic [1:0]       dflag [0:BND_W];
  logic [BND_W-1:0] dquo  [1:BND_W];

  logic [LAT-1:0]   hs_sr;
  logic [LAT-1:0]   vs_sr;

  // Stage-1 combinational work: bound/interval differences and the pixel clamp
  always_comb begin
    v_in     = i_hs & i_vs;
    flag_up  = upbound < lobound;
    flag_iv  = highLevel <= lowLevel;
    bdiff_in = flag_up ? '0 : upbound - lobound;
    intv_in  = flag_iv ? '0 : highLevel - lowLevel;
    if (pixel_in <= lowLevel)
      alpha_in = '0;
    else if (pixel_in >= highLevel)
      alpha_in = intv_in;
    else
      alpha_in = pixel_in - lowLevel;
  end

  // Stage-1 registers; data is zeroed whenever the pixel is not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_bdiff <= '0;
      s1_intv  <= '0;
      s1_alpha <= '0;
      s1_lo    <= '0;
      s1_flag  <= '0;
    end else begin
      s1_v <= v_in;
      if (v_in) begin
        s1_bdiff <= bdiff_in;
        s1_intv  <= intv_in;
        s1_alpha <= alpha_in;
        s1_lo    <= lobound;
        s1_flag  <= {flag_up, flag_iv};
      end else begin
        s1_bdiff <= '0;
        s1_intv  <= '0;
        s1_alpha <= '0;
        s1_lo    <= '0;
        s1_flag  <= '0;
      end
    end
  end

  // Because alpha <= intv and bdiff < 2^BND_W, the dividend stays below intv<<BND_W.
  // This holds even with the half-interval rounding term added.
  assign prod    = {{PIX_W{1'b0}}, s1_bdiff} * {{BND_W{1'b0}}, s1_alpha};
  assign rnd_add = (ROUND != 0) ? {{BND_W{1'b0}}, 1'b0, s1_intv[PIX_W-1:1]} : '0;

  // Stage-2 register: the exact product (plus the rounding term) becomes the dividend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv[0]    <= 1'b0;
      drem[0]  <= '0;
      dintv[0] <= '0;
      dlo[0]   <= '0;
      dflag[0] <= '0;
    end else begin
      dv[0] <= s1_v;
      if (s1_v) begin
        drem[0]  <= prod + rnd_add;
        dintv[0] <= s1_intv;
        dlo[0]   <= s1_lo;
        dflag[0] <= s1_flag;
      end else begin
        drem[0]  <= '0;
        dintv[0] <= '0;
        dlo[0]   <= '0;
        dflag[0] <= '0;
      end
    end
  end

  for (genvar k = 0; k < BND_W; k++) begin : g_div
    localparam int SH = BND_W - 1 - k;
    localparam logic [BND_W-1:0] QBIT = BND_W'(1) << SH;

    logic [PW-1:0]    dsr;
    logic             ge;
    logic [BND_W-1:0] q_prev;

    if (k == 0) begin : g_first
      assign q_prev = '0;
    end else begin : g_rest
      assign q_prev = dquo[k];
    end

    // A zero interval never sets a quotient bit, so the divider is bypassed to 0.
    assign dsr = {{BND_W{1'b0}}, dintv[k]} << SH;
    assign ge  = (dintv[k] != '0) && (drem[k] >= dsr);

    // One restoring-division step: subtract the shifted divisor when it fits
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dv[k+1]    <= 1'b0;
        drem[k+1]  <= '0;
        dquo[k+1]  <= '0;
        dintv[k+1] <= '0;
        dlo[k+1]   <= '0;
        dflag[k+1] <= '0;
      end else begin
        dv[k+1] <= dv[k];
        if (dv[k]) begin
          drem[k+1]  <= ge ? drem[k] - dsr : drem[k];
          dquo[k+1]  <= ge ? (q_prev | QBIT) : q_prev;
          dintv[k+1] <= dintv[k];
          dlo[k+1]   <= dlo[k];
          dflag[k+1] <= dflag[k];
        end else begin
          drem[k+1]  <= '0;
          dquo[k+1]  <= '0;
          dintv[k+1] <= '0;
          dlo[k+1]   <= '0;
          dflag[k+1] <= '0;
        end
      end
    end
  end

  // Output stage: the offset is added back onto lobound. The sum cannot wrap because quotient <= bdiff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_delta <= '0;
      o_value <= '0;
      o_flag  <= '0;
    end else begin
      o_valid <= dv[BND_W];
      if (dv[BND_W]) begin
        o_delta <= dquo[BND_W];
        o_value <= dlo[BND_W] + dquo[BND_W];
        o_flag  <= dflag[BND_W];
      end else begin
        o_delta <= '0;
        o_value <= '0;
        o_flag  <= '0;
      end
    end
  end

  // Sync delay lines, independent of pixel validity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[LAT-2:0], i_hs};
      vs_sr <= {vs_sr[LAT-2:0], i_vs};
    end
  end

  assign o_hs = hs_sr[LAT-1];
  assign o_vs = vs_sr[LAT-1];

endmodule

// File: tb/tb_interpolator_pipe.sv
// Scoreboard bench for interpolator_pipe.
// Floor (ROUND=0) and rounding (ROUND=1) instances run side by side on the same stimulus.
module tb_interpolator_pipe;

  localparam int LAT = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0;
  logic        i_vs = 1'b0;
  logic [10:0] pixel_in = '0;
  logic [10:0] low_level = '0;
  logic [10:0] high_level = '0;
  logic [7:0]  lobound = '0;
  logic [7:0]  upbound = '0;

  logic        o_hs0, o_vs0, o_valid0, o_hs1, o_vs1, o_valid1;
  logic [7:0]  o_delta0, o_value0, o_delta1, o_value1;
  logic [1:0]  o_flag0, o_flag1;

  interpolator_pipe #(.PIX_W(11), .BND_W(8), .ROUND(0)) u_floor (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pixel_in(pixel_in),
    .lowLevel(low_level), .highLevel(high_level), .lobound(lobound), .upbound(upbound),
    .o_hs(o_hs0), .o_vs(o_vs0), .o_valid(o_valid0), .o_delta(o_delta0),
    .o_value(o_value0), .o_flag(o_flag0)
  );

  interpolator_pipe #(.PIX_W(11), .BND_W(8), .ROUND(1)) u_round (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .pixel_in(pixel_in),
    .lowLevel(low_level), .highLevel(high_level), .lobound(lobound), .upbound(upbound),
    .o_hs(o_hs1), .o_vs(o_vs1), .o_valid(o_valid1), .o_delta(o_delta1),
    .o_value(o_value1), .o_flag(o_flag1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; int d0; int d1; int lo; int flag;} exp_t;
  typedef struct {int due; int hs; int vs;} syn_t;
  typedef struct {int pix; int low; int high; int lo; int up; int d0; int d1; int flag;} vec_t;

  exp_t exp_q[$];
  syn_t syn_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int model_delta(int pix, int low, int high, int lo, int up, int rnd);
    int intv, a;
    if (up < lo || high <= low) return 0;
    intv = high - low;
    if (pix <= low) a = 0;
    else if (pix >= high) a = intv;
    else a = pix - low;
    return ((up - lo) * a + (rnd != 0 ? intv / 2 : 0)) / intv;
  endfunction

  task automatic drive(input int hs, input int vs, input int pix, input int low, input int high,
                       input int lo, input int up, input int d0, input int d1, input int flag);
    exp_t e;
    syn_t s;
    @(negedge clk);
    i_hs = hs[0];
    i_vs = vs[0];
    pixel_in = 11'(pix);
    low_level = 11'(low);
    high_level = 11'(high);
    lobound = 8'(lo);
    upbound = 8'(up);
    s.due = cyc + LAT; s.hs = hs; s.vs = vs;
    syn_q.push_back(s);
    if (hs != 0 && vs != 0) begin
      e.due = cyc + LAT; e.d0 = d0; e.d1 = d1; e.lo = lo; e.flag = flag;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_model(input int hs, input int vs, input int pix, input int low,
                             input int high, input int lo, input int up);
    int flag;
    flag = ((up < lo) ? 2 : 0) + ((high <= low) ? 1 : 0);
    drive(hs, vs, pix, low, high, lo, up,
          model_delta(pix, low, high, lo, up, 0), model_delta(pix, low, high, lo, up, 1), flag);
  endtask

  // Monitor: compares every output cycle against whatever the scoreboard holds for that cycle
  always @(negedge clk) begin
    exp_t e;
    syn_t s;
    if (rst_n) begin
      while (syn_q.size() > 0 && syn_q[0].due < cyc) begin
        s = syn_q.pop_front();
        chk("sync_late_due", s.due, cyc);
      end
      if (syn_q.size() > 0 && syn_q[0].due == cyc) begin
        s = syn_q.pop_front();
        chk("sync_floor", {o_hs0, o_vs0}, s.hs * 2 + s.vs);
        chk("sync_round", {o_hs1, o_vs1}, s.hs * 2 + s.vs);
      end else begin
        chk("sync_idle_floor", {o_hs0, o_vs0}, 0);
        chk("sync_idle_round", {o_hs1, o_vs1}, 0);
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        chk("result_late_due", e.due, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("valid_floor", o_valid0, 1);
        chk("valid_round", o_valid1, 1);
        chk("delta_floor", o_delta0, e.d0);
        chk("value_floor", o_value0, e.lo + e.d0);
        chk("flag_floor", o_flag0, e.flag);
        chk("delta_round", o_delta1, e.d1);
        chk("value_round", o_value1, e.lo + e.d1);
        chk("flag_round", o_flag1, e.flag);
      end else begin
        chk("idle_floor", {o_valid0, o_delta0, o_value0, o_flag0}, 0);
        chk("idle_round", {o_valid1, o_delta1, o_value1, o_flag1}, 0);
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk(name, {o_hs0, o_vs0, o_valid0, o_delta0, o_value0, o_flag0,
               o_hs1, o_vs1, o_valid1, o_delta1, o_value1, o_flag1}, 0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs = '{
      '{1004,  500, 1500,  40, 200,  80,  81, 0},
      '{1000,  500, 1500,  40, 200,  80,  80, 0},
      '{2000,  500, 1500,  40, 200, 160, 160, 0},
      '{ 100,  500, 1500,  40, 200,   0,   0, 0},
      '{ 900,  700,  700,  40, 200,   0,   0, 1},
      '{1004,  500, 1500,  40,  30,   0,   0, 2},
      '{ 500,  500, 1500,  40, 200,   0,   0, 0},
      '{1500,  500, 1500,  40, 200, 160, 160, 0},
      '{ 600,  800,  300, 100,  50,   0,   0, 3},
      '{2047,    0, 2047,   0, 255, 255, 255, 0},
      '{   1,    0,    2,   0, 255, 127, 128, 0},
      '{1005,  500, 1500,  40, 200,  80,  81, 0}
    };

    repeat (3) @(negedge clk);
    #1 check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back to back, each with its own levels and bounds
    foreach (vecs[i])
      drive(1, 1, vecs[i].pix, vecs[i].low, vecs[i].high, vecs[i].lo, vecs[i].up,
            vecs[i].d0, vecs[i].d1, vecs[i].flag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Ramp with a 5-cycle hs drop in the middle
    for (int p = 500; p <= 1500; p++) begin
      if (p >= 1000 && p < 1005) drive_model(0, 1, p, 500, 1500, 40, 200);
      else drive_model(1, 1, p, 500, 1500, 40, 200);
    end

    // Mid-stream asynchronous reset
    for (int p = 0; p < 20; p++) drive_model(1, 1, 300 + p * 37, 250, 1200, 17, 233);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    exp_q.delete();
    syn_q.delete();
    i_hs = 1'b0;
    i_vs = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 20; p++) drive_model(1, 1, 1004 + p * 3, 500, 1500, 40, 200);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (LAT + 3) @(negedge clk);
    chk("queues_drained", exp_q.size() + syn_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
